// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants (also used by the timing
// engine), the sync decoder state encoding, and coordinate helpers.
package vga_pkg;

  // 640x480@60 mode, 800x525 totals.
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  // Pixel / line coordinate width; counters saturate at all-ones.
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;
  localparam coord_t COORD_MAX = '1;

  // Decoder lock state.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_t;

  // True when lo <= v <= hi.
  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Increment that sticks at COORD_MAX instead of wrapping.
  function automatic coord_t sat_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: samples one active-low sync line on pixel ticks and flags
// its falling edge (previous sample high, current input low). The previous
// sample resets high so a line that is already low at reset release reads
// as a falling edge on the first tick.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sig,
  output logic fall
);

  logic prev;

  // Previous-sample register, advanced only on pixel ticks.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (!rst) begin
      prev <= 1'b1;
    end else if (en) begin
      prev <= sig;
    end
  end

  assign fall = en & prev & ~sig;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, active-video, line/frame
// strobes and a lock flag from active-low hs/vs qualified by pixEn.
// All outputs are registered and change only on pixEn edges (pulses drop
// to 0 on any non-pixEn edge), so they lag the sampled sync by one tick.
// Optional: define VGA_SYNC_DECODER_ERRCNT_EN to add errCount, a
// saturating count of timingErr pulses cleared only by reset.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixEn,
  input  logic               hs,
  input  logic               vs,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               lineStart,
  output logic               frameStart,
  output logic               locked,
  output logic               timingErr
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  ,
  output logic [7:0]         errCount
`endif
);

  // Active window bounds and expected last count of each axis.
  localparam coord_t H_FIRST = coord_t'(H_SYNC + H_BP);
  localparam coord_t H_LAST  = coord_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam coord_t H_END   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_FIRST = coord_t'(V_SYNC + V_BP);
  localparam coord_t V_LAST  = coord_t'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam coord_t V_END   = coord_t'(V_TOTAL - 1);
  localparam coord_t PRE_MAX = COORD_MAX - coord_t'(1);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  typedef logic [GOOD_W-1:0] good_t;
  localparam good_t GOOD_LOCK = good_t'(LOCK_FRAMES);

  logic       h_fall;
  logic       v_fall;
  coord_t     h_cnt;
  coord_t     v_cnt;
  logic       vs_pend;
  good_t      good_cnt;
  dec_state_t state;

  coord_t     h_nxt;
  coord_t     v_nxt;
  coord_t     x_nxt;
  coord_t     y_nxt;
  logic       pend_nxt;
  good_t      good_nxt;
  dec_state_t state_nxt;
  logic       frame_evt;
  logic       h_mis;
  logic       v_mis;
  logic       h_sat;
  logic       v_sat;
  logic       err;
  logic       act_nxt;

  vga_sync_edge u_hs_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (pixEn),
    .sig  (hs),
    .fall (h_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (pixEn),
    .sig  (vs),
    .fall (v_fall)
  );

  // Next-tick counters, length checks, lock state and output values.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    state_nxt = state;
    good_nxt  = good_cnt;

    // A frame is accepted at the hs edge that follows (or coincides with)
    // a vs falling edge.
    frame_evt = h_fall & (vs_pend | v_fall);
    pend_nxt  = frame_evt ? 1'b0 : (vs_pend | v_fall);

    h_mis = h_fall & (h_cnt != H_END);
    v_mis = frame_evt & (v_cnt != V_END);
    // Sync loss: flag the single tick on which a counter reaches its ceiling.
    h_sat = pixEn & ~h_fall & (h_cnt == PRE_MAX);
    v_sat = h_fall & ~frame_evt & (v_cnt == PRE_MAX);
    err   = (h_mis | v_mis | h_sat | v_sat) & (state != SEARCH);

    h_nxt = h_fall ? '0 : sat_inc(h_cnt);
    if (frame_evt) begin
      v_nxt = '0;
    end else if (h_fall) begin
      v_nxt = sat_inc(v_cnt);
    end else begin
      v_nxt = v_cnt;
    end

    case (state)
      SEARCH: begin
        if (frame_evt) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (err) begin
          good_nxt = '0;
        end else if (frame_evt) begin
          good_nxt = good_cnt + 1'b1;
          if (good_nxt == GOOD_LOCK) begin
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (err) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
      end
    endcase

    act_nxt = in_range(h_nxt, H_FIRST, H_LAST) &
              in_range(v_nxt, V_FIRST, V_LAST) &
              (state_nxt == LOCKED);
    x_nxt   = act_nxt ? h_nxt - H_FIRST : '0;
    y_nxt   = act_nxt ? v_nxt - V_FIRST : '0;
  end

  // Decoder state and registered outputs; everything holds between ticks
  // except the one-clock strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      vs_pend    <= 1'b0;
      good_cnt   <= '0;
      state      <= SEARCH;
      x          <= '0;
      y          <= '0;
      active     <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      locked     <= 1'b0;
      timingErr  <= 1'b0;
    end else if (pixEn) begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      vs_pend    <= pend_nxt;
      good_cnt   <= good_nxt;
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      active     <= act_nxt;
      lineStart  <= h_fall;
      frameStart <= frame_evt;
      locked     <= (state_nxt == LOCKED);
      timingErr  <= err;
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      timingErr  <= 1'b0;
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  // Saturating count of timingErr pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      errCount <= '0;
    end else if (err && (errCount != 8'hFF)) begin
      errCount <= errCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder. The DUT runs a
// reduced timing mode (20x12 totals, window h 7..16, v 4..8) so whole
// frames stay short; expected values below follow from these parameters.
// pixEn is asserted on every second clock. Define
// VGA_SYNC_DECODER_ERRCNT_EN to also check errCount.
module tb_vga_sync_decoder;

  localparam int HS    = 4;
  localparam int HBP   = 3;
  localparam int HA    = 10;
  localparam int HT    = 20;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int VA    = 5;
  localparam int VT    = 12;
  localparam int HST   = HS + HBP;   // 7
  localparam int VST   = VS + VBP;   // 4
  localparam int FRAME = HT * VT;    // 240 pixel ticks

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pixEn = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [10:0] x;
  logic [10:0] y;
  logic        active;
  logic        lineStart;
  logic        frameStart;
  logic        locked;
  logic        timingErr;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0]  errCount;
`endif

  int errors = 0;
  int checks = 0;

  // Sync generator position and stimulus modifiers.
  int gh = 0;
  int gv = 0;
  bit short_line = 1'b0;
  bit vs_early = 1'b0;
  bit hs_stuck = 1'b0;

  // Snapshot of outputs right after the latest pixEn edge.
  int          cur_h;
  int          cur_v;
  logic [10:0] s_x;
  logic [10:0] s_y;
  logic        s_act;
  logic        s_ls;
  logic        s_fs;
  logic        s_lk;
  logic        s_te;

  always #10 clk = ~clk;

  vga_sync_decoder #(
    .H_SYNC      (HS),
    .H_BP        (HBP),
    .H_ACTIVE    (HA),
    .H_TOTAL     (HT),
    .V_SYNC      (VS),
    .V_BP        (VBP),
    .V_ACTIVE    (VA),
    .V_TOTAL     (VT),
    .LOCK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixEn      (pixEn),
    .hs         (hs),
    .vs         (vs),
    .x          (x),
    .y          (y),
    .active     (active),
    .lineStart  (lineStart),
    .frameStart (frameStart),
    .locked     (locked),
    .timingErr  (timingErr)
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    ,
    .errCount   (errCount)
`endif
  );

  function automatic logic gen_hs();
    return hs_stuck ? 1'b1 : (gh >= HS);
  endfunction

  function automatic logic gen_vs();
    if (vs_early && (gv == VT - 1) && (gh == HT - 1)) return 1'b0;
    return (gv >= VS);
  endfunction

  // One clock: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic en, input logic h, input logic v);
    @(negedge clk);
    pixEn = en;
    hs    = h;
    vs    = v;
    @(posedge clk);
    #1;
  endtask

  // One pixel tick (pixEn clock then idle clock); snapshots outputs after the tick.
  task automatic pix();
    logic h;
    logic v;
    h = gen_hs();
    v = gen_vs();
    cur_h = gh;
    cur_v = gv;
    step(1'b1, h, v);
    s_x   = x;
    s_y   = y;
    s_act = active;
    s_ls  = lineStart;
    s_fs  = frameStart;
    s_lk  = locked;
    s_te  = timingErr;
    step(1'b0, h, v);
    gh++;
    if (gh >= (short_line ? HT - 1 : HT)) begin
      gh = 0;
      short_line = 1'b0;
      gv++;
      if (gv == VT) gv = 0;
    end
  endtask

  // Advance until the snapshot position equals (h, v); bounded.
  task automatic run_to(input int h, input int v, output bit found);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      pix();
      if (cur_h == h && cur_v == v) found = 1'b1;
    end
  endtask

  // Advance until locked is seen, counting frameStarts and timingErrs; bounded.
  task automatic run_until_locked(output bit ok, output int fs_n, output int te_n);
    ok   = 1'b0;
    fs_n = 0;
    te_n = 0;
    for (int i = 0; i < 5 * FRAME && !ok; i++) begin
      pix();
      if (s_fs) fs_n++;
      if (s_te) te_n++;
      if (s_lk) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b1);
    checks++;
    if ({x, y} !== 22'd0) begin
      errors++;
      $display("FAIL reset_xy: got x=%0d y=%0d, expected 0 0", x, y);
    end
    checks++;
    if ({active, locked} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got active=%b locked=%b, expected 0 0", active, locked);
    end
    checks++;
    if ({lineStart, frameStart, timingErr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b, expected 000", {lineStart, frameStart, timingErr});
    end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    checks++;
    if (errCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_errcount: got %0d, expected 0", errCount);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ideal_stream();
    int fs_n = 0;
    int ls_n = 0;
    int te_n = 0;
    int lock_fs = -1;
    int lock_f = -1;
    int bad_xy = 0;
    int act_n[4];
    int first_h = -1;
    int first_v = -1;
    int first_x = -1;
    int first_y = -1;
    int last_h = -1;
    int last_v = -1;
    int last_x = -1;
    int last_y = -1;
    for (int f = 0; f < 4; f++) begin
      act_n[f] = 0;
      for (int i = 0; i < FRAME; i++) begin
        pix();
        if (s_fs) fs_n++;
        if (s_ls) ls_n++;
        if (s_te) te_n++;
        if (s_lk && lock_fs < 0) begin
          lock_fs = fs_n;
          lock_f  = f;
        end
        if (s_act) begin
          act_n[f]++;
          if (f == 2) begin
            if (first_h < 0) begin
              first_h = cur_h;
              first_v = cur_v;
              first_x = int'(s_x);
              first_y = int'(s_y);
            end
            last_h = cur_h;
            last_v = cur_v;
            last_x = int'(s_x);
            last_y = int'(s_y);
          end
          if (s_x !== 11'(cur_h - HST) || s_y !== 11'(cur_v - VST)) bad_xy++;
        end else if (s_x !== 11'd0 || s_y !== 11'd0) begin
          bad_xy++;
        end
      end
    end
    checks++;
    if (lock_fs != 3 || lock_f != 2) begin
      errors++;
      $display("FAIL lock_rise: got frameStart#%0d frame %0d, expected #3 frame 2", lock_fs, lock_f);
    end
    checks++;
    if (act_n[0] != 0 || act_n[1] != 0) begin
      errors++;
      $display("FAIL active_unlocked: got %0d/%0d, expected 0/0", act_n[0], act_n[1]);
    end
    checks++;
    if (act_n[2] != HA * VA || act_n[3] != HA * VA) begin
      errors++;
      $display("FAIL active_count: got %0d/%0d, expected %0d", act_n[2], act_n[3], HA * VA);
    end
    checks++;
    if (first_h != HST || first_v != VST || first_x != 0 || first_y != 0) begin
      errors++;
      $display("FAIL first_active: got h=%0d v=%0d x=%0d y=%0d, expected 7 4 0 0",
               first_h, first_v, first_x, first_y);
    end
    checks++;
    if (last_h != HST + HA - 1 || last_v != VST + VA - 1 || last_x != HA - 1 || last_y != VA - 1) begin
      errors++;
      $display("FAIL last_active: got h=%0d v=%0d x=%0d y=%0d, expected 16 8 9 4",
               last_h, last_v, last_x, last_y);
    end
    checks++;
    if (bad_xy != 0) begin
      errors++;
      $display("FAIL coords: got %0d bad ticks, expected 0", bad_xy);
    end
    checks++;
    if (ls_n != 4 * VT || fs_n != 4) begin
      errors++;
      $display("FAIL strobes: got lineStart=%0d frameStart=%0d, expected 48 4", ls_n, fs_n);
    end
    checks++;
    if (te_n != 0) begin
      errors++;
      $display("FAIL ideal_err: got %0d timingErr, expected 0", te_n);
    end
  endtask

  task automatic test_short_line();
    int  te_n = 0;
    int  fs_n;
    int  te_r;
    bit  ok;
    for (int i = 0; i < 5 * HT; i++) pix();
    short_line = 1'b1;
    for (int i = 0; i < HT - 1; i++) begin
      pix();
      if (s_te) te_n++;
    end
    pix();
    checks++;
    if (te_n != 0 || s_te !== 1'b1) begin
      errors++;
      $display("FAIL short_err: got early=%0d edge=%b, expected 0 1", te_n, s_te);
    end
    checks++;
    if (s_lk !== 1'b0) begin
      errors++;
      $display("FAIL short_unlock: got locked=%b, expected 0", s_lk);
    end
    for (int i = 0; i < HST; i++) pix();
    checks++;
    if (s_act !== 1'b0 || s_x !== 11'd0) begin
      errors++;
      $display("FAIL short_inactive: got active=%b x=%0d, expected 0 0", s_act, s_x);
    end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    checks++;
    if (errCount !== 8'd1) begin
      errors++;
      $display("FAIL short_errcount: got %0d, expected 1", errCount);
    end
`endif
    run_until_locked(ok, fs_n, te_r);
    checks++;
    if (!ok || fs_n != 3 || te_r != 0) begin
      errors++;
      $display("FAIL short_relock: got ok=%b frameStarts=%0d errs=%0d, expected 1 3 0", ok, fs_n, te_r);
    end
  endtask

  task automatic test_vs_align();
    bit found;
    run_to(HT - 2, VT - 1, found);
    vs_early = 1'b1;
    pix();
    checks++;
    if (!found || s_fs !== 1'b0) begin
      errors++;
      $display("FAIL vs_early_pend: got found=%b frameStart=%b, expected 1 0", found, s_fs);
    end
    pix();
    vs_early = 1'b0;
    checks++;
    if (s_fs !== 1'b1 || s_ls !== 1'b1 || s_te !== 1'b0 || s_lk !== 1'b1) begin
      errors++;
      $display("FAIL vs_early_edge: got fs=%b ls=%b te=%b lk=%b, expected 1 1 0 1",
               s_fs, s_ls, s_te, s_lk);
    end
    run_to(HST, VST, found);
    checks++;
    if (!found || s_act !== 1'b1 || s_x !== 11'd0 || s_y !== 11'd0) begin
      errors++;
      $display("FAIL vs_early_origin: got act=%b x=%0d y=%0d, expected 1 0 0", s_act, s_x, s_y);
    end
    run_to(0, 0, found);
    checks++;
    if (!found || s_fs !== 1'b1 || s_te !== 1'b0 || s_lk !== 1'b1) begin
      errors++;
      $display("FAIL vs_same_edge: got fs=%b te=%b lk=%b, expected 1 0 1", s_fs, s_te, s_lk);
    end
    run_to(HST, VST, found);
    checks++;
    if (!found || s_act !== 1'b1 || s_y !== 11'd0) begin
      errors++;
      $display("FAIL vs_same_origin: got act=%b y=%0d, expected 1 0", s_act, s_y);
    end
  endtask

  task automatic test_pixen_hold();
    bit found;
    int bad = 0;
    int te_n = 0;
    run_to(10, 5, found);
    checks++;
    if (!found || s_x !== 11'd3 || s_y !== 11'd1 || s_act !== 1'b1) begin
      errors++;
      $display("FAIL hold_start: got x=%0d y=%0d act=%b, expected 3 1 1", s_x, s_y, s_act);
    end
    // Sync lines wiggle during the hold; nothing may be sampled.
    for (int i = 0; i < 100; i++) begin
      step(1'b0, (i >= 20 && i < 60) ? 1'b0 : 1'b1, (i >= 40 && i < 80) ? 1'b0 : 1'b1);
      if (x !== 11'd3 || y !== 11'd1 || active !== 1'b1 || locked !== 1'b1 ||
          lineStart !== 1'b0 || frameStart !== 1'b0 || timingErr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_frozen: got %0d bad clocks, expected 0", bad);
    end
    pix();
    checks++;
    if (s_x !== 11'd4 || s_y !== 11'd1 || s_te !== 1'b0) begin
      errors++;
      $display("FAIL hold_resume: got x=%0d y=%0d te=%b, expected 4 1 0", s_x, s_y, s_te);
    end
    for (int i = 0; i < FRAME; i++) begin
      pix();
      if (s_te) te_n++;
    end
    checks++;
    if (te_n != 0 || s_lk !== 1'b1) begin
      errors++;
      $display("FAIL hold_after: got errs=%0d locked=%b, expected 0 1", te_n, s_lk);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit ok;
    int fs_n;
    int te_n;
    run_to(10, 5, found);
    @(negedge clk);
    rst   = 1'b0;
    pixEn = 1'b1;
    hs    = gen_hs();
    vs    = gen_vs();
    @(posedge clk);
    #1;
    checks++;
    if (!found || {x, y, active, locked} !== 24'd0 ||
        {lineStart, frameStart, timingErr} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_out: got x=%0d y=%0d act=%b lk=%b, expected all 0", x, y, active, locked);
    end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    checks++;
    if (errCount !== 8'd0) begin
      errors++;
      $display("FAIL midreset_errcount: got %0d, expected 0", errCount);
    end
`endif
    rst = 1'b1;
    run_until_locked(ok, fs_n, te_n);
    checks++;
    if (!ok || fs_n != 3 || te_n != 0) begin
      errors++;
      $display("FAIL midreset_relock: got ok=%b frameStarts=%0d errs=%0d, expected 1 3 0", ok, fs_n, te_n);
    end
  endtask

  task automatic test_hs_stuck();
    bit found = 1'b0;
    int te_n = 0;
    int te_at = -1;
    for (int i = 0; i < 2 * HT && !found; i++) begin
      pix();
      if (cur_h == HT - 1) found = 1'b1;
    end
    checks++;
    if (!found || s_lk !== 1'b1) begin
      errors++;
      $display("FAIL stuck_pre: got found=%b locked=%b, expected 1 1", found, s_lk);
    end
    // hCnt is 19 here; it reaches 2047 on stuck tick 2028.
    hs_stuck = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      pix();
      if (s_te) begin
        te_n++;
        if (te_at < 0) te_at = k;
      end
    end
    hs_stuck = 1'b0;
    checks++;
    if (te_n != 1 || te_at != 2028) begin
      errors++;
      $display("FAIL stuck_err: got %0d pulses at tick %0d, expected 1 at 2028", te_n, te_at);
    end
    checks++;
    if (s_lk !== 1'b0 || s_act !== 1'b0) begin
      errors++;
      $display("FAIL stuck_unlock: got locked=%b active=%b, expected 0 0", s_lk, s_act);
    end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    checks++;
    if (errCount !== 8'd1) begin
      errors++;
      $display("FAIL stuck_errcount: got %0d, expected 1", errCount);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ideal_stream();
    test_short_line();
    test_vs_align();
    test_pixen_hold();
    test_reset_mid();
    test_hs_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
